// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic MAC-array sequencer.
package systolic_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int N_DEF          = 3;
    localparam int M_DEF          = 3;
    localparam int K_MAX_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } sched_state_t;

    // Read latency + skew/propagation + MAC register stage.
    function automatic int drain_count(input int n, input int m);
        return n + m;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_sched_skew_line.sv
// skew_line: DEPTH-stage register delay with async clear; DEPTH=0 degenerates to a wire.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_q      = i_d;
    end else begin : g_regs
        logic [WIDTH-1:0] r_stage [DEPTH];

        // NOTE: every stage is cleared on reset (it is a flop chain, not a RAM) so an aborted
        // job leaves nothing in flight; non-blocking updates make the shift order irrelevant.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
            end else begin
                r_stage[0] <= i_d;
                for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_sched.sv
// Job sequencer for the N x M output-stationary MAC array: clear, feed skewed operands, drain, done.
// Optional SYSTOLIC_SCHED_PERF_EN adds saturating perf_jobs / perf_busy counters.
module systolic_sched
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N          = N_DEF,
    parameter int M          = M_DEF,
    parameter int K_MAX      = K_MAX_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    output logic                         busy,
    output logic                         done,
    output logic                         mac_clr,
    output logic                         a_rd_en,
    output logic [ADDR_WIDTH-1:0]        a_rd_addr,
    input  logic [N*DATA_WIDTH-1:0]      a_rd_data,
    output logic                         b_rd_en,
    output logic [ADDR_WIDTH-1:0]        b_rd_addr,
    input  logic [M*DATA_WIDTH-1:0]      b_rd_data,
    output logic [N*DATA_WIDTH-1:0]      a_feed,
    output logic [M*DATA_WIDTH-1:0]      b_feed
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    output logic [31:0]                  perf_jobs,
    output logic [31:0]                  perf_busy
`endif
);

    localparam int KL_W      = $clog2(K_MAX + 1);
    localparam int DRAIN_CYC = drain_count(N, M);
    localparam int CNT_MAX   = (K_MAX > DRAIN_CYC) ? K_MAX : DRAIN_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    sched_state_t     r_state, w_state_next;
    logic [KL_W-1:0]  r_kl;
    logic [KL_W-1:0]  w_kl_sat;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rd_vld;
    logic             w_feed_last;
    logic             w_drain_last;
    logic             w_rd_en;

    assign w_kl_sat     = (k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len;
    assign w_feed_last  = (r_cnt == CNT_W'(r_kl) - CNT_W'(1));
    assign w_drain_last = (r_cnt == CNT_W'(DRAIN_CYC - 1));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        done         = 1'b0;
        mac_clr      = 1'b0;
        w_rd_en      = 1'b0;
        unique case (r_state)
            IDLE:    if (start) w_state_next = CLEAR;
            CLEAR: begin
                mac_clr      = 1'b1;
                w_state_next = (r_kl == '0) ? DONE : FEED;
            end
            FEED: begin
                w_rd_en = 1'b1;
                if (w_feed_last) w_state_next = DRAIN;
            end
            DRAIN:   if (w_drain_last) w_state_next = DONE;
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_kl     <= '0;
            r_cnt    <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rd_vld <= w_rd_en;
            if (r_state == IDLE && start) r_kl <= w_kl_sat;
            // Counter restarts on every state change and only advances while feeding/draining.
            if ((r_state == FEED || r_state == DRAIN) && w_state_next == r_state)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

    assign a_rd_en   = w_rd_en;
    assign b_rd_en   = w_rd_en;
    assign a_rd_addr = w_rd_en ? ADDR_WIDTH'(r_cnt) : '0;
    assign b_rd_addr = a_rd_addr;

    for (genvar i = 0; i < N; i++) begin : g_a_lane
        logic [DATA_WIDTH:0] w_q;
        skew_line #(.WIDTH(DATA_WIDTH + 1), .DEPTH(i)) u_skew (
            .clk (clk),
            .rst (rst),
            .i_d ({r_rd_vld, a_rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]}),
            .o_q (w_q)
        );
        assign a_feed[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
            w_q[DATA_WIDTH] ? w_q[DATA_WIDTH-1:0] : '0;
    end

    for (genvar j = 0; j < M; j++) begin : g_b_lane
        logic [DATA_WIDTH:0] w_q;
        skew_line #(.WIDTH(DATA_WIDTH + 1), .DEPTH(j)) u_skew (
            .clk (clk),
            .rst (rst),
            .i_d ({r_rd_vld, b_rd_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH]}),
            .o_q (w_q)
        );
        assign b_feed[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] =
            w_q[DATA_WIDTH] ? w_q[DATA_WIDTH-1:0] : '0;
    end

`ifdef SYSTOLIC_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_jobs <= '0;
            perf_busy <= '0;
        end else begin
            if (done && perf_jobs != '1) perf_jobs <= perf_jobs + 32'd1;
            if (busy && perf_busy != '1) perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule
